// File: rtl/cdr_pkg.sv
// Shared CDR definitions: phase-controller FSM states and default loop parameters.
package cdr_pkg;

    typedef enum logic {
        PC_ACQ   = 1'b0,
        PC_TRACK = 1'b1
    } pc_state_t;

    localparam int unsigned PC_PW        = 6;
    localparam int unsigned PC_RST_PHASE = 8;
    localparam int unsigned PC_ACQ_TH    = 1;
    localparam int unsigned PC_TRK_TH    = 4;
    localparam int unsigned PC_AW        = 4;
    localparam int unsigned PC_LOCK_WIN  = 16;
    localparam int unsigned PC_FW        = 8;

endpackage : cdr_pkg

// File: rtl/lock_det.sv
// Lock detector: counts consecutive direction-alternating (dither) phase steps.
// Ports:
//   clk_cont, rst   : clock, async active-high reset
//   clr             : synchronous clear (pointer load)
//   step, dir       : a phase step happened this cycle, dir=1 means up
//   run_nxt_c       : combinational next value of the run counter
//   locked          : registered, run >= LOCK_WIN
module lock_det #(
    parameter int unsigned LOCK_WIN = 16,
    parameter int unsigned RW       = $clog2(LOCK_WIN + 1)
) (
    input  logic          clk_cont,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    input  logic          dir,
    output logic [RW-1:0] run_nxt_c,
    output logic          locked
);

    logic [RW-1:0] run;
    logic          last_dir;
    logic          have_dir;   // cleared until the first step after reset/clear

    // Alternating step extends the run (saturating); a repeat or the first step restarts it.
    always_comb begin
        run_nxt_c = run;
        if (clr) begin
            run_nxt_c = '0;
        end else if (step) begin
            if (have_dir && (dir != last_dir)) begin
                run_nxt_c = (run == RW'(LOCK_WIN)) ? run : run + RW'(1);
            end else begin
                run_nxt_c = '0;
            end
        end
    end

    always_ff @(posedge clk_cont or posedge rst) begin
        if (rst) begin
            run      <= '0;
            last_dir <= 1'b0;
            have_dir <= 1'b0;
            locked   <= 1'b0;
        end else begin
            run    <= run_nxt_c;
            locked <= (run_nxt_c >= RW'(LOCK_WIN));
            if (clr) begin
                have_dir <= 1'b0;
            end else if (step) begin
                last_dir <= dir;
                have_dir <= 1'b1;
            end
        end
    end

endmodule : lock_det

// File: rtl/pi_phase_ctrl.sv
// Bang-bang CDR loop filter and phase-interpolator pointer.
// Votes pass through a threshold accumulator (gain set by ACQ/TRACK state) and
// step a circular PW-bit pointer; lock is declared after LOCK_WIN dither steps.
// Optional feature macro: SECOND_ORDER_EN adds a frequency integrator (freq)
// and phase accumulator (facc) whose overflow contributes extra pointer steps.
// Ports:
//   clk_cont, rst     : clock, async active-high reset
//   up, down          : phase votes (both high counts as no vote)
//   hold              : freeze the whole loop
//   load, load_val    : synchronous pointer load (highest priority)
//   vs                : registered interpolator phase select
//   step_up, step_dn  : registered one-cycle pulses, sign of this cycle's pointer change
//   locked            : registered lock indicator
module pi_phase_ctrl
    import cdr_pkg::*;
#(
    parameter int unsigned PW        = PC_PW,
    parameter int unsigned RST_PHASE = PC_RST_PHASE,
    parameter int unsigned ACQ_TH    = PC_ACQ_TH,
    parameter int unsigned TRK_TH    = PC_TRK_TH,
    parameter int unsigned AW        = PC_AW,
    parameter int unsigned LOCK_WIN  = PC_LOCK_WIN
`ifdef SECOND_ORDER_EN
    ,
    parameter int unsigned FW        = PC_FW
`endif
) (
    input  logic          clk_cont,
    input  logic          rst,
    input  logic          up,
    input  logic          down,
    input  logic          hold,
    input  logic          load,
    input  logic [PW-1:0] load_val,
    output logic [PW-1:0] vs,
    output logic          step_up,
    output logic          step_dn,
    output logic          locked
);

    localparam int unsigned RW = $clog2(LOCK_WIN + 1);

    pc_state_t            state, state_nxt;
    logic signed [AW-1:0] acc, acc_nxt, nacc, vote, th;
    logic [PW-1:0]        vs_nxt;
    logic                 step_up_nxt, step_dn_nxt;
    logic                 p_up_c, p_dn_c;
    logic signed [2:0]    prop_c, fstep_c, net_c;
    logic [RW-1:0]        run_nxt_c;

    // Proportional path: vote into accumulator, compare against state-dependent threshold.
    always_comb begin
        vote = '0;
        if (up && !down)      vote = AW'(1);
        else if (down && !up) vote = -AW'(1);
        nacc   = acc + vote;
        th     = (state == PC_ACQ) ? AW'(ACQ_TH) : AW'(TRK_TH);
        p_up_c = 1'b0;
        p_dn_c = 1'b0;
        if (!load && !hold) begin
            if (nacc >= th)       p_up_c = 1'b1;
            else if (nacc <= -th) p_dn_c = 1'b1;
        end
        prop_c = p_up_c ? 3'sd1 : (p_dn_c ? -3'sd1 : 3'sd0);
        net_c  = prop_c + fstep_c;
    end

    lock_det #(
        .LOCK_WIN (LOCK_WIN),
        .RW       (RW)
    ) u_lock_det (
        .clk_cont  (clk_cont),
        .rst       (rst),
        .clr       (load),
        .step      (p_up_c | p_dn_c),
        .dir       (p_up_c),
        .run_nxt_c (run_nxt_c),
        .locked    (locked)
    );

`ifdef SECOND_ORDER_EN
    localparam logic signed [FW-1:0] F_MAX  = FW'(2**(FW-1) - 1);
    localparam logic signed [FW+1:0] F_SPAN = (FW+2)'(2**FW);

    logic signed [FW-1:0] freq, freq_nxt;
    logic signed [FW:0]   facc, facc_nxt;
    logic signed [FW+1:0] fsum;

    // Frequency integrator follows proportional steps; facc overflow yields an extra step.
    always_comb begin
        freq_nxt = freq;
        facc_nxt = facc;
        fstep_c  = 3'sd0;
        fsum     = (FW+2)'(facc) + (FW+2)'(freq);
        if (load) begin
            facc_nxt = '0;
        end else if (!hold) begin
            if (p_up_c && (freq != F_MAX))       freq_nxt = freq + FW'(1);
            else if (p_dn_c && (freq != -F_MAX)) freq_nxt = freq - FW'(1);
            if (fsum >= F_SPAN) begin
                facc_nxt = (FW+1)'(fsum - F_SPAN);
                fstep_c  = 3'sd1;
            end else if (fsum <= -F_SPAN) begin
                facc_nxt = (FW+1)'(fsum + F_SPAN);
                fstep_c  = -3'sd1;
            end else begin
                facc_nxt = (FW+1)'(fsum);
            end
        end
    end

    always_ff @(posedge clk_cont or posedge rst) begin
        if (rst) begin
            freq <= '0;
            facc <= '0;
        end else begin
            freq <= freq_nxt;
            facc <= facc_nxt;
        end
    end
`else
    assign fstep_c = 3'sd0;
`endif

    // Next-state and next-output logic: load > hold > normal.
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        vs_nxt      = vs;
        step_up_nxt = 1'b0;
        step_dn_nxt = 1'b0;
        if (load) begin
            vs_nxt    = load_val;
            acc_nxt   = '0;
            state_nxt = PC_ACQ;
        end else if (!hold) begin
            acc_nxt     = (p_up_c || p_dn_c) ? '0 : nacc;
            vs_nxt      = vs + PW'(net_c);
            step_up_nxt = (net_c > 3'sd0);
            step_dn_nxt = (net_c < 3'sd0);
            if (run_nxt_c == RW'(LOCK_WIN))              state_nxt = PC_TRACK;
            else if ((p_up_c || p_dn_c) && run_nxt_c == '0) state_nxt = PC_ACQ;
            if (state_nxt != state) acc_nxt = '0;
        end
    end

    always_ff @(posedge clk_cont or posedge rst) begin
        if (rst) begin
            state   <= PC_ACQ;
            acc     <= '0;
            vs      <= PW'(RST_PHASE);
            step_up <= 1'b0;
            step_dn <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            vs      <= vs_nxt;
            step_up <= step_up_nxt;
            step_dn <= step_dn_nxt;
        end
    end

endmodule : pi_phase_ctrl

// File: tb/tb_pi_phase_ctrl.sv
// Directed bench for pi_phase_ctrl (default first-order build).
module tb_pi_phase_ctrl;

    logic       clk_cont = 1'b0;
    logic       rst      = 1'b1;
    logic       up       = 1'b0;
    logic       down     = 1'b0;
    logic       hold     = 1'b0;
    logic       load     = 1'b0;
    logic [5:0] load_val = '0;
    logic [5:0] vs;
    logic       step_up, step_dn, locked;

    int n_chk = 0;
    int n_bad = 0;

    pi_phase_ctrl dut (
        .clk_cont (clk_cont),
        .rst      (rst),
        .up       (up),
        .down     (down),
        .hold     (hold),
        .load     (load),
        .load_val (load_val),
        .vs       (vs),
        .step_up  (step_up),
        .step_dn  (step_dn),
        .locked   (locked)
    );

    always #5 clk_cont = ~clk_cont;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_cont);
        #1;
    endtask

    // One clock with the given vote, then compare all outputs.
    task automatic vote(input logic u, input logic d, input string tag,
                        input int e_vs, input int e_up, input int e_dn, input int e_lk);
        up   = u;
        down = d;
        tick();
        check({tag, ".vs"},      int'(vs),      e_vs);
        check({tag, ".step_up"}, int'(step_up), e_up);
        check({tag, ".step_dn"}, int'(step_dn), e_dn);
        check({tag, ".locked"},  int'(locked),  e_lk);
    endtask

    initial begin
        int e_vs;

        // Reset state
        #12;
        check("rst.vs", int'(vs), 8);
        check("rst.locked", int'(locked), 0);
        check("rst.step", int'({step_up, step_dn}), 0);
        rst = 1'b0;
        tick();

        // ACQ gain: each up vote steps immediately
        vote(1, 0, "acq1", 9, 1, 0, 0);
        vote(1, 0, "acq2", 10, 1, 0, 0);
        vote(1, 0, "acq3", 11, 1, 0, 0);
        vote(0, 0, "idle", 11, 0, 0, 0);

        // Async reset in the middle of stepping
        vote(1, 0, "pre_rst", 12, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("arst.vs", int'(vs), 8);
        check("arst.step_up", int'(step_up), 0);
        check("arst.locked", int'(locked), 0);
        up = 1'b0;
        #1 rst = 1'b0;
        tick();

        // Pointer wrap in both directions
        load = 1'b1; load_val = 6'd63;
        vote(0, 0, "ld63", 63, 0, 0, 0);
        load = 1'b0;
        vote(1, 0, "wrap_up", 0, 1, 0, 0);
        load = 1'b1; load_val = 6'd0;
        vote(0, 0, "ld0", 0, 0, 0, 0);
        load = 1'b0;
        vote(0, 1, "wrap_dn", 63, 0, 1, 0);

        // Dither: 17 alternating steps (first counts as a repeat) reach lock
        load = 1'b1; load_val = 6'd32;
        vote(0, 0, "ld32", 32, 0, 0, 0);
        load = 1'b0;
        for (int i = 0; i < 17; i++) begin
            e_vs = (i % 2 == 0) ? 31 : 32;
            vote(i % 2 == 1, i % 2 == 0, $sformatf("dither%0d", i), e_vs,
                 (i % 2 == 1) ? 1 : 0, (i % 2 == 0) ? 1 : 0, (i == 16) ? 1 : 0);
        end

        // TRACK gain: four votes per step; direction change keeps lock
        vote(1, 0, "trk1", 31, 0, 0, 1);
        vote(1, 0, "trk2", 31, 0, 0, 1);
        vote(1, 0, "trk3", 31, 0, 0, 1);
        vote(1, 0, "trk4", 32, 1, 0, 1);

        // Repeat step in TRACK drops lock and returns to ACQ gain
        vote(1, 0, "rep1", 32, 0, 0, 1);
        vote(1, 0, "rep2", 32, 0, 0, 1);
        vote(1, 0, "rep3", 32, 0, 0, 1);
        vote(1, 0, "rep4", 33, 1, 0, 0);
        vote(1, 0, "acq_again", 34, 1, 0, 0);

        // Both votes high is no vote; hold freezes the loop
        vote(1, 1, "both", 34, 0, 0, 0);
        hold = 1'b1;
        vote(1, 0, "hold1", 34, 0, 0, 0);
        vote(0, 1, "hold2", 34, 0, 0, 0);

        // load beats hold
        load = 1'b1; load_val = 6'd5;
        vote(1, 0, "ld_hold", 5, 0, 0, 0);
        load = 1'b0; hold = 1'b0;
        vote(1, 0, "post_ld", 6, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_pi_phase_ctrl
